// File: rtl/spi_sts_fault_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_sts_fault_encoder
// Purpose  : Sits after the SPI status synchronizer. Detects new (rising-edge)
//            fault events on 81 status sources, holds them in a pending
//            vector, and drains them one per cycle (lowest index first) into a
//            first-word-fall-through FIFO of 8-bit fault codes for software.
//            Also keeps a sticky fault/interrupt flag, the first queued code
//            and a sticky lost-event flag.
// Ports    : aclk                      system clock
//            areset                    synchronous active-high reset
//            clear                     one-cycle clear of sticky state + FIFO
//            spi_off_stable            SPI-off level (source 80, code 8'h78)
//            *_stable [7:0] (x10)      per-channel status, fault types 0..9
//            code_dout [7:0]           FIFO head {1'b0, type[3:0], ch[2:0]}
//            code_valid                FIFO non-empty
//            code_rd_en                pop head when code_valid
//            code_count [CNT_W-1:0]    FIFO occupancy
//            fault                     sticky "a code was queued" / interrupt
//            first_code [7:0]          first code queued since reset/clear
//            lost_event                sticky "rise on an already-pending source"
// Revision : 1.0  initial release
// ============================================================================
module spi_sts_fault_encoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             clear,
  input  logic             spi_off_stable,
  input  logic [7:0]       dac_over_thresh_stable,
  input  logic [7:0]       adc_over_thresh_stable,
  input  logic [7:0]       dac_thresh_underflow_stable,
  input  logic [7:0]       dac_thresh_overflow_stable,
  input  logic [7:0]       adc_thresh_underflow_stable,
  input  logic [7:0]       adc_thresh_overflow_stable,
  input  logic [7:0]       dac_buf_underflow_stable,
  input  logic [7:0]       adc_buf_overflow_stable,
  input  logic [7:0]       unexp_dac_trig_stable,
  input  logic [7:0]       unexp_adc_trig_stable,
  output logic [7:0]       code_dout,
  output logic             code_valid,
  input  logic             code_rd_en,
  output logic [CNT_W-1:0] code_count,
  output logic             fault,
  output logic [7:0]       first_code,
  output logic             lost_event
);

  localparam int         c_NSRC         = 81;
  localparam int         c_IDX_W        = 7;
  localparam int         c_PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [6:0] c_SPI_OFF_IDX  = 7'd80;
  localparam logic [7:0] c_SPI_OFF_CODE = 8'h78;

  // --------------------------------------------------------------------------
  // Source vector: bit index = type*8 + channel, SPI-off on top at index 80.
  // --------------------------------------------------------------------------
  logic [c_NSRC-1:0] w_in;

  assign w_in = {spi_off_stable,
                 unexp_adc_trig_stable,
                 unexp_dac_trig_stable,
                 adc_buf_overflow_stable,
                 dac_buf_underflow_stable,
                 adc_thresh_overflow_stable,
                 adc_thresh_underflow_stable,
                 dac_thresh_overflow_stable,
                 dac_thresh_underflow_stable,
                 adc_over_thresh_stable,
                 dac_over_thresh_stable};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_NSRC-1:0]  r_prev;
  logic [c_NSRC-1:0]  r_pending;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_fault;
  logic [7:0]         r_first_code;
  logic               r_lost;

  // --------------------------------------------------------------------------
  // Edge detect and FIFO handshake
  // --------------------------------------------------------------------------
  logic [c_NSRC-1:0] w_rise;
  logic              w_valid;
  logic              w_full;
  logic              w_pop;
  logic              w_can_push;

  // prev clears to zero on reset so levels already high at release count as
  // new events; clear leaves prev alone so held levels do not fire again.
  assign w_rise     = w_in & ~r_prev;
  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = code_rd_en & w_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_can_push = ~w_full | w_pop;

  // --------------------------------------------------------------------------
  // Fixed-priority scanner: lowest pending index wins.
  // --------------------------------------------------------------------------
  logic               w_src_pend;
  logic [c_IDX_W-1:0] w_src_idx;

  always_comb begin
    w_src_pend = 1'b0;
    w_src_idx  = '0;
    // Walking downward makes the last hit the lowest set index.
    for (int i = c_NSRC - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_src_pend = 1'b1;
        w_src_idx  = c_IDX_W'(i);
      end
    end
  end

  logic              w_grant;
  logic [c_NSRC-1:0] w_grant_vec;
  logic [7:0]        w_code;
  logic              w_lost;

  assign w_grant     = w_src_pend & w_can_push;
  assign w_grant_vec = w_grant ? (c_NSRC'(1) << w_src_idx) : '0;

  // For indices below 80 the index bits split directly into type and channel.
  assign w_code = (w_src_idx == c_SPI_OFF_IDX) ? c_SPI_OFF_CODE
                                               : {1'b0, w_src_idx[6:3], w_src_idx[2:0]};

  // A rise on the bit granted this cycle simply re-arms it, so it is not lost.
  assign w_lost = |(w_rise & r_pending & ~w_grant_vec);

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_prev       <= '0;
      r_pending    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_fault      <= 1'b0;
      r_first_code <= 8'h00;
      r_lost       <= 1'b0;
    end else begin
      r_prev <= w_in;
      if (clear) begin
        // Any rise, grant or pop in the clear cycle is discarded.
        r_pending    <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_fault      <= 1'b0;
        r_first_code <= 8'h00;
        r_lost       <= 1'b0;
      end else begin
        r_pending <= (r_pending & ~w_grant_vec) | w_rise;

        if (w_grant) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end

        if (w_grant && !w_pop) begin
          r_count <= r_count + CNT_W'(1);
        end else if (!w_grant && w_pop) begin
          r_count <= r_count - CNT_W'(1);
        end

        if (w_grant && !r_fault) begin
          r_fault      <= 1'b1;
          r_first_code <= w_code;
        end

        if (w_lost) begin
          r_lost <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. When full with a pop, wr_ptr equals rd_ptr: the head is read
  // combinationally this cycle and its slot is rewritten as the new tail.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!areset && !clear && w_grant) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Head is forced to zero while empty so stale storage never shows.
  assign code_dout  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign code_valid = w_valid;
  assign code_count = r_count;
  assign fault      = r_fault;
  assign first_code = r_first_code;
  assign lost_event = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_spi_sts_fault_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sts_fault_encoder
// Purpose  : Self-checking bench for spi_sts_fault_encoder. A queue-based
//            model tracks pending sources and queued codes; every cycle the
//            DUT outputs are compared against it, and directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_sts_fault_encoder;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          spi_off;
  logic [7:0]    st [0:9];
  logic          rd;
  logic [7:0]    code_dout;
  logic          code_valid;
  logic [CW-1:0] code_count;
  logic          fault;
  logic [7:0]    first_code;
  logic          lost_event;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_sts_fault_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .aclk                        (clk),
    .areset                      (rst),
    .clear                       (clr),
    .spi_off_stable              (spi_off),
    .dac_over_thresh_stable      (st[0]),
    .adc_over_thresh_stable      (st[1]),
    .dac_thresh_underflow_stable (st[2]),
    .dac_thresh_overflow_stable  (st[3]),
    .adc_thresh_underflow_stable (st[4]),
    .adc_thresh_overflow_stable  (st[5]),
    .dac_buf_underflow_stable    (st[6]),
    .adc_buf_overflow_stable     (st[7]),
    .unexp_dac_trig_stable       (st[8]),
    .unexp_adc_trig_stable       (st[9]),
    .code_dout                   (code_dout),
    .code_valid                  (code_valid),
    .code_rd_en                  (rd),
    .code_count                  (code_count),
    .fault                       (fault),
    .first_code                  (first_code),
    .lost_event                  (lost_event)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  bit   m_prev [0:80];
  bit   m_pend [0:80];
  int   m_q [$];
  bit   m_fault;
  int   m_first;
  bit   m_lost;
  bit   m_started = 1'b0;

  function automatic int code_of(input int idx);
    if (idx == 80) return 8'h78;
    return (idx / 8) * 8 + (idx % 8);   // type in [6:3], channel in [2:0]
  endfunction

  function automatic bit src_level(input int idx);
    if (idx == 80) return spi_off;
    return st[idx / 8][idx % 8];
  endfunction

  always @(posedge clk) begin
    bit lvl [0:80];
    bit rise [0:80];
    bit pop;
    int g;
    for (int i = 0; i <= 80; i++) lvl[i] = src_level(i);
    m_started = 1'b1;
    if (rst) begin
      for (int i = 0; i <= 80; i++) begin
        m_prev[i] = 1'b0;
        m_pend[i] = 1'b0;
      end
      m_q.delete();
      m_fault = 1'b0;
      m_first = 0;
      m_lost  = 1'b0;
    end else begin
      for (int i = 0; i <= 80; i++) rise[i] = lvl[i] && !m_prev[i];
      pop = rd && (m_q.size() > 0);
      g = -1;
      if (m_q.size() < DEPTH || pop) begin
        for (int i = 80; i >= 0; i--) if (m_pend[i]) g = i;
      end
      if (clr) begin
        for (int i = 0; i <= 80; i++) m_pend[i] = 1'b0;
        m_q.delete();
        m_fault = 1'b0;
        m_first = 0;
        m_lost  = 1'b0;
      end else begin
        for (int i = 0; i <= 80; i++)
          if (rise[i] && m_pend[i] && i != g) m_lost = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
          m_q.push_back(code_of(g));
          if (!m_fault) begin
            m_fault = 1'b1;
            m_first = code_of(g);
          end
          m_pend[g] = 1'b0;
        end
        for (int i = 0; i <= 80; i++) if (rise[i]) m_pend[i] = 1'b1;
      end
      for (int i = 0; i <= 80; i++) m_prev[i] = lvl[i];
    end
  end

  // Continuous comparison on the falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("m_valid", int'(code_valid), int'(m_q.size() > 0));
      chk("m_dout",  int'(code_dout),  (m_q.size() > 0) ? m_q[0] : 0);
      chk("m_count", int'(code_count), m_q.size());
      chk("m_fault", int'(fault),      int'(m_fault));
      chk("m_first", int'(first_code), m_first);
      chk("m_lost",  int'(lost_event), int'(m_lost));
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    int n48;
    rst = 1'b1; clr = 1'b0; rd = 1'b0; spi_off = 1'b0;
    for (int i = 0; i < 10; i++) st[i] = 8'h00;
    tick(3);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_count", int'(code_count), 0);
    chk("rst_dout",  int'(code_dout),  0);
    chk("rst_fault", int'(fault),      0);
    chk("rst_first", int'(first_code), 0);
    chk("rst_lost",  int'(lost_event), 0);
    rst = 1'b0;
    tick(5);

    // Single event: dac_over_thresh[3] -> 8'h03 two cycles later.
    st[0][3] = 1'b1;
    tick(1);
    chk("t1_early_valid", int'(code_valid), 0);
    tick(1);
    chk("t1_dout",  int'(code_dout),  8'h03);
    chk("t1_valid", int'(code_valid), 1);
    chk("t1_fault", int'(fault),      1);
    chk("t1_first", int'(first_code), 8'h03);
    chk("t1_count", int'(code_count), 1);
    rd = 1'b1; tick(1); rd = 1'b0;
    chk("t1_popped", int'(code_count), 0);

    // Two simultaneous sources: lower index first.
    pulse_clear();
    tick(2);
    chk("t2_noretrig", int'(code_count), 0);
    st[7][5] = 1'b1;
    st[0][1] = 1'b1;
    tick(2);
    chk("t2_dout0", int'(code_dout),  8'h01);
    chk("t2_first", int'(first_code), 8'h01);
    tick(1);
    chk("t2_count", int'(code_count), 2);
    rd = 1'b1; tick(1);
    chk("t2_dout1", int'(code_dout), 8'h3D);
    tick(1); rd = 1'b0;
    chk("t2_empty", int'(code_count), 0);

    // 17 simultaneous rises: FIFO fills, 17th waits until a pop.
    pulse_clear();
    st[1] = 8'hFF; st[2] = 8'hFF; st[9][0] = 1'b1;
    tick(20);
    chk("t3_full",  int'(code_count), 16);
    chk("t3_head",  int'(code_dout),  8'h08);
    chk("t3_lost0", int'(lost_event), 0);
    rd = 1'b1; tick(1); rd = 1'b0;
    chk("t3_refill", int'(code_count), 16);
    chk("t3_head2",  int'(code_dout),  8'h09);
    tick(2);
    chk("t3_lost1", int'(lost_event), 0);

    // Re-arm while full: second rise on a pending source is lost.
    pulse_clear();
    st[1] = 8'h00; st[2] = 8'h00; st[9][0] = 1'b0;
    tick(1);
    st[1] = 8'hFF; st[2] = 8'hFF; st[9][0] = 1'b1;
    tick(20);
    chk("t4_full", int'(code_count), 16);
    st[9][0] = 1'b0; tick(1);
    st[9][0] = 1'b1; tick(1);
    chk("t4_lost", int'(lost_event), 1);
    n48 = 0;
    rd = 1'b1;
    repeat (30) begin
      if (code_valid && code_dout == 8'h48) n48++;
      @(negedge clk);
    end
    rd = 1'b0;
    chk("t4_one_48", n48, 1);
    chk("t4_drained", int'(code_count), 0);

    // SPI-off then clear with levels held.
    spi_off = 1'b1;
    tick(2);
    chk("t5_dout", int'(code_dout),  8'h78);
    chk("t5_count", int'(code_count), 1);
    pulse_clear();
    tick(3);
    chk("t5_clr_count", int'(code_count), 0);
    chk("t5_clr_fault", int'(fault),      0);
    chk("t5_clr_lost",  int'(lost_event), 0);
    chk("t5_clr_first", int'(first_code), 0);

    // Levels held through reset release are reported.
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(2);
    chk("t6_dout",  int'(code_dout),  8'h01);
    chk("t6_valid", int'(code_valid), 1);
    chk("t6_first", int'(first_code), 8'h01);

    // Reset mid-operation.
    tick(5);
    rst = 1'b1; tick(1);
    chk("t7_count", int'(code_count), 0);
    chk("t7_valid", int'(code_valid), 0);
    chk("t7_fault", int'(fault),      0);
    chk("t7_dout",  int'(code_dout),  0);
    rst = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
